// File: rtl/avalon_sdr_responder.sv
// Avalon-MM responder standing in for a 16-bit SDRAM port. It provides halfword
// storage with pipelined reads, a cap on outstanding reads and optional periodic stalls.
module avalon_sdr_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_address,
  input  logic [15:0] avs_s0_writedata,
  input  logic [1:0]  avs_s0_byteenable,
  output logic        avs_s0_waitrequest,
  output logic [15:0] avs_s0_readdata,
  output logic        avs_s0_readdatavalid,
  output logic        err_range,
  output logic        err_unaligned,
  output logic        err_proto,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic [3:0]    PEND_MAX   = 4'(MAX_PENDING);

  logic [7:0]              mem_lo [DEPTH];
  logic [7:0]              mem_hi [DEPTH];
  logic [SW-1:0]           stall_cnt;
  logic [3:0]              pending;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [15:0]             pipe_data [READ_LATENCY];

  logic                    stall_active;
  logic                    ret_now;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [15:0]             rd_word;

  assign stall_active = (STALL_PERIOD != 0) && (stall_cnt == '0);
  assign ret_now      = pipe_valid[READ_LATENCY-1];

  // A return in the same cycle frees a slot, so a read at the cap may still go in.
  assign avs_s0_waitrequest = reset || stall_active ||
                              (avs_s0_read && (pending == PEND_MAX) && !ret_now);

  assign accept = (avs_s0_read || avs_s0_write) && !avs_s0_waitrequest;
  assign wr_acc = accept && avs_s0_write;
  assign rd_acc = accept && avs_s0_read && !avs_s0_write;

  assign idx      = avs_s0_address[DEPTH_LOG2:1];
  assign in_range = (avs_s0_address[31:DEPTH_LOG2+1] == '0);
  assign rd_word  = in_range ? {mem_hi[idx], mem_lo[idx]} : 16'h0000;

  assign avs_s0_readdatavalid = pipe_valid[READ_LATENCY-1];
  assign avs_s0_readdata      = pipe_data[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset || (STALL_PERIOD == 0)) begin
      stall_cnt <= '0;
    end else if (stall_cnt == STALL_LAST) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Memory deliberately has no reset so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      if (avs_s0_byteenable[0]) mem_lo[idx] <= avs_s0_writedata[7:0];
      if (avs_s0_byteenable[1]) mem_hi[idx] <= avs_s0_writedata[15:8];
    end
  end

  // Data only moves with its valid bit, so the last stage holds the previous return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= 16'h0000;
    end else begin
      pipe_valid[0] <= rd_acc;
      if (rd_acc) pipe_data[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= 4'd0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
      err_range     <= 1'b0;
      err_unaligned <= 1'b0;
      err_proto     <= 1'b0;
    end else begin
      if (rd_acc && !ret_now) begin
        pending <= pending + 4'd1;
      end else if (!rd_acc && ret_now) begin
        pending <= pending - 4'd1;
      end
      if (rd_acc) rd_count <= rd_count + 16'd1;
      if (wr_acc) wr_count <= wr_count + 16'd1;
      if (accept && !in_range) err_range <= 1'b1;
      if (accept && avs_s0_address[0]) err_unaligned <= 1'b1;
      if (accept && avs_s0_read && avs_s0_write) err_proto <= 1'b1;
    end
  end

endmodule
